// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch. Owns the PC, drives the ROM address, loads the
//            IF/ID register, and handles stall, redirect and fetch faults.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                       PC_WIDTH    = 16,
    parameter int                       INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]      RESET_PC    = 16'h0000,
    parameter int                       IM_BYTES    = 256,
    parameter logic [INSTR_WIDTH-1:0]   NOP_INSTR   = 32'h00000013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    output logic [PC_WIDTH-1:0]    im_pc_o,
    input  logic [INSTR_WIDTH-1:0] im_instr_i,
    output logic                   id_valid_o,
    output logic [PC_WIDTH-1:0]    id_pc_o,
    output logic [PC_WIDTH-1:0]    id_pc4_o,
    output logic [INSTR_WIDTH-1:0] id_instr_o,
    output logic [1:0]             fault_o,
    output logic [31:0]            fetch_cnt_o
);

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [31:0]         IM_LIMIT = 32'(IM_BYTES);
    localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4);

    state_t               state;
    logic [PC_WIDTH-1:0]  pc;
    logic [PC_WIDTH-1:0]  pc_next4;
    logic                 in_range;

    assign im_pc_o  = pc;
    assign pc_next4 = pc + PC_STEP;
    // Zero-extend before comparing so IM_BYTES may equal 2^PC_WIDTH.
    assign in_range = (32'(pc) < IM_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            id_valid_o  <= 1'b0;
            id_pc_o     <= '0;
            id_pc4_o    <= '0;
            id_instr_o  <= NOP_INSTR;
            fault_o     <= 2'b00;
            fetch_cnt_o <= 32'd0;
        end else begin
            case (state)
                BOOT: begin
                    id_valid_o <= 1'b0;
                    id_instr_o <= NOP_INSTR;
                    state      <= RUN;
                end
                RUN: begin
                    if (redirect_i) begin
                        pc         <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
                        id_valid_o <= 1'b0;
                        id_instr_o <= NOP_INSTR;
                        if (redirect_pc_i[1:0] != 2'b00) begin
                            fault_o[0] <= 1'b1;
                        end
                    end else if (stall_i) begin
                        pc <= pc;
                    end else if (in_range) begin
                        id_valid_o  <= 1'b1;
                        id_pc_o     <= pc;
                        id_pc4_o    <= pc_next4;
                        id_instr_o  <= im_instr_i;
                        pc          <= pc_next4;
                        fetch_cnt_o <= fetch_cnt_o + 32'd1;
                    end else begin
                        // Parked beyond the ROM: emit bubbles until redirected.
                        id_valid_o <= 1'b0;
                        id_instr_o <= NOP_INSTR;
                        fault_o[1] <= 1'b1;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage with a ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic [15:0] im_pc_o;
    logic [31:0] im_instr_i;
    logic        id_valid_o;
    logic [15:0] id_pc_o;
    logic [15:0] id_pc4_o;
    logic [31:0] id_instr_o;
    logic [1:0]  fault_o;
    logic [31:0] fetch_cnt_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] rom [64];

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .im_pc_o       (im_pc_o),
        .im_instr_i    (im_instr_i),
        .id_valid_o    (id_valid_o),
        .id_pc_o       (id_pc_o),
        .id_pc4_o      (id_pc4_o),
        .id_instr_o    (id_instr_o),
        .fault_o       (fault_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign im_instr_i = (im_pc_o < 16'h0100) ? rom[im_pc_o[7:2]] : 32'hDEADBEEF;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hA0000000 + 32'(i);
        rom[0] = 32'h40000593;
        rom[1] = 32'h40058593;

        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 16'h0000;
        step(); step();
        chk("rst_pc",     32'(im_pc_o),    32'h0);
        chk("rst_valid",  32'(id_valid_o), 32'h0);
        chk("rst_idpc",   32'(id_pc_o),    32'h0);
        chk("rst_instr",  id_instr_o,      NOP);
        chk("rst_fault",  32'(fault_o),    32'h0);
        chk("rst_cnt",    fetch_cnt_o,     32'h0);

        // Free run: BOOT bubble then sequential fetches
        rst = 1'b0;
        step();
        chk("boot_valid", 32'(id_valid_o), 32'h0);
        chk("boot_pc",    32'(im_pc_o),    32'h0);
        step();
        chk("f0_valid",   32'(id_valid_o), 32'h1);
        chk("f0_pc",      32'(id_pc_o),    32'h0);
        chk("f0_pc4",     32'(id_pc4_o),   32'h4);
        chk("f0_instr",   id_instr_o,      32'h40000593);
        step();
        chk("f1_pc",      32'(id_pc_o),    32'h4);
        chk("f1_instr",   id_instr_o,      32'h40058593);
        step();
        chk("f2_pc",      32'(id_pc_o),    32'h8);
        chk("f2_cnt",     fetch_cnt_o,     32'd3);
        step();
        chk("f3_pc",      32'(id_pc_o),    32'hC);
        chk("f3_impc",    32'(im_pc_o),    32'h10);

        // Stall at pc=0x10
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_impc", 32'(im_pc_o),  32'h10);
            chk("stall_idpc", 32'(id_pc_o),  32'hC);
            chk("stall_cnt",  fetch_cnt_o,   32'd4);
        end
        stall_i = 1'b0;
        step();
        chk("unstall_idpc",  32'(id_pc_o),    32'h10);
        chk("unstall_instr", id_instr_o,      32'hA0000004);
        chk("unstall_cnt",   fetch_cnt_o,     32'd5);

        // Redirect wins over stall
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 16'h003C;
        step();
        chk("rd_impc",  32'(im_pc_o),    32'h3C);
        chk("rd_valid", 32'(id_valid_o), 32'h0);
        chk("rd_instr", id_instr_o,      NOP);
        chk("rd_idpc",  32'(id_pc_o),    32'h10);
        redirect_i = 1'b0; stall_i = 1'b0;
        step();
        chk("rd_tgt_valid", 32'(id_valid_o), 32'h1);
        chk("rd_tgt_pc",    32'(id_pc_o),    32'h3C);
        chk("rd_tgt_cnt",   fetch_cnt_o,     32'd6);

        // Misaligned redirect
        redirect_i = 1'b1; redirect_pc_i = 16'h004E;
        step();
        chk("mis_impc",  32'(im_pc_o), 32'h4C);
        chk("mis_fault", 32'(fault_o), 32'h1);
        redirect_i = 1'b0;
        step();
        chk("mis_idpc",   32'(id_pc_o),  32'h4C);
        chk("mis_sticky", 32'(fault_o),  32'h1);

        // Run off the end of the ROM
        redirect_i = 1'b1; redirect_pc_i = 16'h00F8;
        step();
        redirect_i = 1'b0;
        step();
        chk("end_f8", 32'(id_pc_o), 32'hF8);
        step();
        chk("end_fc_valid", 32'(id_valid_o), 32'h1);
        chk("end_fc_pc",    32'(id_pc_o),    32'hFC);
        chk("end_fc_pc4",   32'(id_pc4_o),   32'h100);
        chk("end_fc_instr", id_instr_o,      32'hA000003F);
        chk("end_fc_cnt",   fetch_cnt_o,     32'd9);
        chk("end_impc",     32'(im_pc_o),    32'h100);
        step();
        chk("park_valid", 32'(id_valid_o), 32'h0);
        chk("park_fault", 32'(fault_o),    32'h3);
        chk("park_pc",    32'(im_pc_o),    32'h100);
        step();
        chk("park2_pc",   32'(im_pc_o),    32'h100);
        chk("park2_cnt",  fetch_cnt_o,     32'd9);
        chk("park2_instr", id_instr_o,     NOP);
        redirect_i = 1'b1; redirect_pc_i = 16'h0000;
        step();
        chk("resume_impc", 32'(im_pc_o), 32'h0);
        redirect_i = 1'b0;
        step();
        chk("resume_valid", 32'(id_valid_o), 32'h1);
        chk("resume_instr", id_instr_o,      32'h40000593);
        chk("resume_cnt",   fetch_cnt_o,     32'd10);

        // Reset mid-operation at pc=0x40 with a valid instruction in ID
        redirect_i = 1'b1; redirect_pc_i = 16'h003C;
        step();
        redirect_i = 1'b0;
        step();
        chk("pre_rst_valid", 32'(id_valid_o), 32'h1);
        chk("pre_rst_pc",    32'(im_pc_o),    32'h40);
        rst = 1'b1;
        step();
        chk("mrst_pc",    32'(im_pc_o),    32'h0);
        chk("mrst_valid", 32'(id_valid_o), 32'h0);
        chk("mrst_fault", 32'(fault_o),    32'h0);
        chk("mrst_cnt",   fetch_cnt_o,     32'h0);
        chk("mrst_pc4",   32'(id_pc4_o),   32'h0);
        // Redirect during BOOT is ignored
        rst = 1'b0; redirect_i = 1'b1; redirect_pc_i = 16'h0082;
        step();
        chk("boot2_valid", 32'(id_valid_o), 32'h0);
        chk("boot2_impc",  32'(im_pc_o),    32'h0);
        chk("boot2_fault", 32'(fault_o),    32'h0);
        redirect_i = 1'b0;
        step();
        chk("post_idpc",  32'(id_pc_o),    32'h0);
        chk("post_valid", 32'(id_valid_o), 32'h1);
        chk("post_cnt",   fetch_cnt_o,     32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
